// File: rtl/fetch_stage_if.sv
// Fetch-side bus bundle: instruction-memory req/ack port plus the fetch->decode
// payload and the decode/execute control inputs that steer fetch.
interface fetch_stage_if #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned INSTR_W = 24
);
  // instruction memory
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  // fetch -> decode
  logic [INSTR_W-1:0] instr_f;
  logic [ADDR_W-1:0]  increPC_f;
  logic [ADDR_W-1:0]  pc_f;
  logic               nop_D;
  // pipeline control into fetch
  logic               stall_d;
  logic               redirect_e;
  logic [ADDR_W-1:0]  target_e;

  modport master (
    output imem_req, imem_addr, instr_f, increPC_f, pc_f, nop_D,
    input  imem_ack, imem_rdata, stall_d, redirect_e, target_e
  );

  modport slave (
    input  imem_req, imem_addr, instr_f, increPC_f, pc_f, nop_D,
    output imem_ack, imem_rdata, stall_d, redirect_e, target_e
  );
endinterface

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, issues one-at-a-time imem requests,
// buffers one instruction while decode stalls, and flushes on execute redirects.
// Optional macro FETCH_JMP_PREDICT_EN: static predict-taken for unconditional
// jmp (insCode 4'b0100), next PC taken from the word's [15:8] field.
module fetch_stage #(
  parameter int unsigned       ADDR_W   = 8,
  parameter int unsigned       INSTR_W  = 24,
  parameter int unsigned       PC_STEP  = 3,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input logic           clk,
  input logic           rst_n,
  fetch_stage_if.master bus
);

  localparam logic [1:0] S_REQ   = 2'd0;
  localparam logic [1:0] S_HOLD  = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;

  logic [1:0]         state_q,      state_nx;
  logic [ADDR_W-1:0]  pc_q,         pc_nx;
  logic [ADDR_W-1:0]  addr_q,       addr_nx;
  logic               req_q,        req_nx;
  logic [INSTR_W-1:0] hold_instr_q, hold_instr_nx;
  logic [ADDR_W-1:0]  hold_pc_q,    hold_pc_nx;
  logic [INSTR_W-1:0] instr_q,      instr_nx;
  logic [ADDR_W-1:0]  pc_f_q,       pc_f_nx;
  logic [ADDR_W-1:0]  incr_q,       incr_nx;
  logic               nop_q,        nop_nx;

  logic               ack_v;
  logic [ADDR_W-1:0]  pc_inc;
  logic [ADDR_W-1:0]  pc_seq;

  // An ack only counts against a request actually on the bus
  assign ack_v  = bus.imem_ack && req_q;
  assign pc_inc = pc_q + ADDR_W'(PC_STEP);

  // Next PC after accepting the word currently on imem_rdata
`ifdef FETCH_JMP_PREDICT_EN
  logic is_jmp;
  assign is_jmp = (bus.imem_rdata[INSTR_W-1 -: 4] == 4'b0100);
  assign pc_seq = is_jmp ? ADDR_W'(bus.imem_rdata[15:8]) : pc_inc;
`else
  assign pc_seq = pc_inc;
`endif

  // State register and all datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      addr_q       <= RESET_PC;
      req_q        <= 1'b0;
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
      instr_q      <= '0;
      pc_f_q       <= '0;
      incr_q       <= '0;
      nop_q        <= 1'b1;
    end else begin
      state_q      <= state_nx;
      pc_q         <= pc_nx;
      addr_q       <= addr_nx;
      req_q        <= req_nx;
      hold_instr_q <= hold_instr_nx;
      hold_pc_q    <= hold_pc_nx;
      instr_q      <= instr_nx;
      pc_f_q       <= pc_f_nx;
      incr_q       <= incr_nx;
      nop_q        <= nop_nx;
    end
  end

  // Next-state, PC, hold-buffer and output-register logic
  always_comb begin
    state_nx      = state_q;
    pc_nx         = pc_q;
    hold_instr_nx = hold_instr_q;
    hold_pc_nx    = hold_pc_q;
    instr_nx      = instr_q;
    pc_f_nx       = pc_f_q;
    incr_nx       = incr_q;
    nop_nx        = nop_q;

    if (bus.redirect_e) begin
      // Flush wins over everything, including a decode stall
      pc_nx         = bus.target_e;
      instr_nx      = '0;
      nop_nx        = 1'b1;
      hold_instr_nx = '0;
      hold_pc_nx    = '0;
      // A request still in flight must be drained before the new PC goes out
      if (state_q != S_HOLD && req_q && !bus.imem_ack) state_nx = S_FLUSH;
      else                                              state_nx = S_REQ;
    end else begin
      case (state_q)
        S_REQ: begin
          if (ack_v) begin
            pc_nx = pc_seq;
            if (!bus.stall_d) begin
              instr_nx = bus.imem_rdata;
              pc_f_nx  = pc_q;
              incr_nx  = pc_inc;
              nop_nx   = 1'b0;
            end else begin
              hold_instr_nx = bus.imem_rdata;
              hold_pc_nx    = pc_q;
              state_nx      = S_HOLD;
            end
          end else if (!bus.stall_d) begin
            instr_nx = '0;
            nop_nx   = 1'b1;
          end
        end
        S_HOLD: begin
          if (!bus.stall_d) begin
            instr_nx = hold_instr_q;
            pc_f_nx  = hold_pc_q;
            incr_nx  = hold_pc_q + ADDR_W'(PC_STEP);
            nop_nx   = 1'b0;
            state_nx = S_REQ;
          end
        end
        S_FLUSH: begin
          if (ack_v) state_nx = S_REQ;
          if (!bus.stall_d) begin
            instr_nx = '0;
            nop_nx   = 1'b1;
          end
        end
        default: state_nx = S_REQ;
      endcase
    end
  end

  // Request stays up except while holding; a flush keeps the stale address
  assign req_nx  = (state_nx != S_HOLD);
  assign addr_nx = (state_nx == S_FLUSH) ? addr_q : pc_nx;

  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.instr_f   = instr_q;
  assign bus.pc_f      = pc_f_q;
  assign bus.increPC_f = incr_q;
  assign bus.nop_D     = nop_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: streaming, stall/hold, memory latency,
// redirect with outstanding request, PC wrap, and jmp prediction.
module tb_fetch_stage;

  logic clk;
  logic rst_n;

  int checks;
  int failures;

  int lat;
  int cnt;
  logic ack_block;
  logic jmp_en;

  fetch_stage_if #(.ADDR_W(8), .INSTR_W(24)) bus ();

  fetch_stage dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory image: ordinary words are {insCode 1, funCode 0, addr, ~addr}
  function automatic logic [23:0] word(input logic [7:0] a);
    if (jmp_en && a == 8'h06) return 24'h40_2000;
    return {4'h1, 4'h0, a, ~a};
  endfunction

  // Response model: ack after `lat` waiting cycles unless blocked
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt <= 0;
    else if (bus.imem_req && !bus.imem_ack) cnt <= cnt + 1;
    else cnt <= 0;
  end

  assign bus.imem_ack   = bus.imem_req && !ack_block && (cnt >= lat);
  assign bus.imem_rdata = word(bus.imem_addr);

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    lat = 0;
    ack_block = 1'b0;
    jmp_en = 1'b0;
    rst_n = 1'b0;
    bus.stall_d = 1'b0;
    bus.redirect_e = 1'b0;
    bus.target_e = 8'h00;

    // Reset state
    step();
    step();
    check("rst_req",   32'(bus.imem_req),  32'h0);
    check("rst_nop",   32'(bus.nop_D),     32'h1);
    check("rst_instr", 32'(bus.instr_f),   32'h0);
    check("rst_pc_f",  32'(bus.pc_f),      32'h0);
    check("rst_incr",  32'(bus.increPC_f), 32'h0);
    rst_n = 1'b1;

    // First cycle after release: request to 00 raised, still a bubble
    step();
    check("c1_req",  32'(bus.imem_req),  32'h1);
    check("c1_addr", 32'(bus.imem_addr), 32'h00);
    check("c1_nop",  32'(bus.nop_D),     32'h1);

    // Back-to-back streaming with same-cycle ack
    step();
    check("s0_instr", 32'(bus.instr_f),   32'h10_00FF);
    check("s0_pc_f",  32'(bus.pc_f),      32'h00);
    check("s0_incr",  32'(bus.increPC_f), 32'h03);
    check("s0_nop",   32'(bus.nop_D),     32'h0);
    step();
    check("s1_instr", 32'(bus.instr_f),   32'h10_03FC);
    check("s1_pc_f",  32'(bus.pc_f),      32'h03);
    check("s1_incr",  32'(bus.increPC_f), 32'h06);
    check("s1_addr",  32'(bus.imem_addr), 32'h06);

    // Stall 3 cycles while the word at 06 is acked
    bus.stall_d = 1'b1;
    step();
    check("st1_instr", 32'(bus.instr_f),  32'h10_03FC);
    check("st1_req",   32'(bus.imem_req), 32'h0);
    step();
    check("st2_instr", 32'(bus.instr_f),  32'h10_03FC);
    check("st2_req",   32'(bus.imem_req), 32'h0);
    step();
    check("st3_instr", 32'(bus.instr_f),  32'h10_03FC);
    check("st3_pc_f",  32'(bus.pc_f),     32'h03);
    bus.stall_d = 1'b0;
    step();
    check("rel_instr", 32'(bus.instr_f),   32'h10_06F9);
    check("rel_pc_f",  32'(bus.pc_f),      32'h06);
    check("rel_incr",  32'(bus.increPC_f), 32'h09);
    check("rel_nop",   32'(bus.nop_D),     32'h0);
    check("rel_addr",  32'(bus.imem_addr), 32'h09);
    check("rel_req",   32'(bus.imem_req),  32'h1);
    step();
    check("nodup_pc_f",  32'(bus.pc_f),    32'h09);
    check("nodup_instr", 32'(bus.instr_f), 32'h10_09F6);

    // Two-cycle memory latency: bubbles, address stable
    lat = 2;
    step();
    check("lat1_nop",  32'(bus.nop_D),     32'h1);
    check("lat1_addr", 32'(bus.imem_addr), 32'h0C);
    step();
    check("lat2_nop",  32'(bus.nop_D),     32'h1);
    check("lat2_addr", 32'(bus.imem_addr), 32'h0C);
    step();
    check("lat3_instr", 32'(bus.instr_f), 32'h10_0CF3);
    check("lat3_pc_f",  32'(bus.pc_f),    32'h0C);
    check("lat3_nop",   32'(bus.nop_D),   32'h0);

    // Redirect to 30 while the request to 0F is outstanding
    lat = 0;
    ack_block = 1'b1;
    step();
    check("ob_addr", 32'(bus.imem_addr), 32'h0F);
    check("ob_nop",  32'(bus.nop_D),     32'h1);
    bus.redirect_e = 1'b1;
    bus.target_e = 8'h30;
    step();
    bus.redirect_e = 1'b0;
    check("fl_nop",   32'(bus.nop_D),     32'h1);
    check("fl_instr", 32'(bus.instr_f),   32'h0);
    check("fl_addr",  32'(bus.imem_addr), 32'h0F);
    check("fl_req",   32'(bus.imem_req),  32'h1);
    check("fl_pc_f",  32'(bus.pc_f),      32'h0C);
    ack_block = 1'b0;
    step();
    check("dr_addr", 32'(bus.imem_addr), 32'h30);
    check("dr_nop",  32'(bus.nop_D),     32'h1);
    step();
    check("tg_instr", 32'(bus.instr_f),   32'h10_30CF);
    check("tg_pc_f",  32'(bus.pc_f),      32'h30);
    check("tg_incr",  32'(bus.increPC_f), 32'h33);

    // Redirect with same-cycle ack: data discarded, jump to FE
    bus.redirect_e = 1'b1;
    bus.target_e = 8'hFE;
    step();
    bus.redirect_e = 1'b0;
    check("rfe_addr", 32'(bus.imem_addr), 32'hFE);
    check("rfe_nop",  32'(bus.nop_D),     32'h1);
    check("rfe_pc_f", 32'(bus.pc_f),      32'h30);
    step();
    check("wrap_pc_f", 32'(bus.pc_f),      32'hFE);
    check("wrap_incr", 32'(bus.increPC_f), 32'h01);
    check("wrap_addr", 32'(bus.imem_addr), 32'h01);
    check("wrap_inst", 32'(bus.instr_f),   32'h10_FE01);

    // jmp word at 06
    jmp_en = 1'b1;
    bus.redirect_e = 1'b1;
    bus.target_e = 8'h06;
    step();
    bus.redirect_e = 1'b0;
    check("j_addr0", 32'(bus.imem_addr), 32'h06);
    step();
    check("j_instr", 32'(bus.instr_f),   32'h40_2000);
    check("j_pc_f",  32'(bus.pc_f),      32'h06);
    check("j_incr",  32'(bus.increPC_f), 32'h09);
`ifdef FETCH_JMP_PREDICT_EN
    check("j_next", 32'(bus.imem_addr), 32'h20);
`else
    check("j_next", 32'(bus.imem_addr), 32'h09);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
